controle_varredura: RTL

//   Upstream sequencer for the 4:1 4-bit routing mux. Drives the mux select
//   so that enabled channels (A,B,C,D = 0..3) are scanned round-robin, each

---
 rtl/controle_varredura_if.sv | 27 ++
 rtl/controle_varredura.sv | 123 ++++++++++++
 2 files changed

// File: rtl/controle_varredura_if.sv
// Signal bundle between the scan sequencer and the 4:1 routing mux / its user.
// The master side is the sequencer itself; the slave side is whoever drives controls and the mux.
interface controle_varredura_if #(
    parameter int W = 4
);
    logic         start;
    logic         stop;
    logic         modo_manual;
    logic [1:0]   sel_manual;
    logic [3:0]   mascara;
    logic [W-1:0] amostra;
    logic [1:0]   sel;
    logic [W-1:0] captura;
    logic [1:0]   canal_cap;
    logic         valido;
    logic         ocupado;

    modport master (
        input  start, stop, modo_manual, sel_manual, mascara, amostra,
        output sel, captura, canal_cap, valido, ocupado
    );

    modport slave (
        output start, stop, modo_manual, sel_manual, mascara, amostra,
        input  sel, captura, canal_cap, valido, ocupado
    );
endinterface

// File: rtl/controle_varredura.sv
// Round-robin scan sequencer for a 4:1 mux: holds each enabled channel for DWELL
// cycles, captures the mux output at the end of each dwell, or passes a manual select.
module controle_varredura #(
    parameter int DWELL = 4,
    parameter int W     = 4
) (
    input  logic              clock,
    input  logic              reset,
    controle_varredura_if.master bus
);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [0:0]    state_r;
    logic [CW-1:0] cnt_r;
    logic [1:0]    sel_r;
    logic [W-1:0]  captura_r;
    logic [1:0]    canal_cap_r;
    logic          valido_r;
    logic          ocupado_r;

    logic [1:0]    primeiro_s;
    logic [1:0]    proximo_s;
    logic          sair_s;

    // Lowest enabled channel index; only meaningful when the mask is non-zero.
    function automatic logic [1:0] primeiro_canal(input logic [3:0] m);
        logic [1:0] r;
        if (m[0]) begin
            r = 2'd0;
        end else if (m[1]) begin
            r = 2'd1;
        end else if (m[2]) begin
            r = 2'd2;
        end else begin
            r = 2'd3;
        end
        return r;
    endfunction

    // First enabled channel after cur, wrapping mod 4; returns cur itself if it is the only one.
    function automatic logic [1:0] proximo_canal(input logic [1:0] cur, input logic [3:0] m);
        logic [1:0] r;
        logic [1:0] cand;
        logic       achou;
        r     = cur;
        achou = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = cur + k[1:0];
            if (!achou && m[cand]) begin
                r     = cand;
                achou = 1'b1;
            end else begin
                r     = r;
            end
        end
        return r;
    endfunction

    // Next-channel candidates and the scan-abort condition.
    always_comb begin
        primeiro_s = primeiro_canal(bus.mascara);
        proximo_s  = proximo_canal(sel_r, bus.mascara);
        sair_s     = bus.stop | bus.modo_manual | (bus.mascara == 4'b0000);
    end

    // Sequencer state, select, dwell counter and capture register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            sel_r       <= 2'd0;
            captura_r   <= '0;
            canal_cap_r <= 2'd0;
            valido_r    <= 1'b0;
            ocupado_r   <= 1'b0;
        end else begin
            valido_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.modo_manual) begin
                        sel_r <= bus.sel_manual;
                    end else if (bus.start && (bus.mascara != 4'b0000)) begin
                        sel_r     <= primeiro_s;
                        cnt_r     <= '0;
                        state_r   <= SCAN;
                        ocupado_r <= 1'b1;
                    end else begin
                        sel_r <= sel_r;
                    end
                end
                SCAN: begin
                    // Abort wins over a coinciding capture so a stopped scan never reports a sample.
                    if (sair_s) begin
                        state_r   <= IDLE;
                        ocupado_r <= 1'b0;
                    end else if (cnt_r == CNT_MAX) begin
                        captura_r   <= bus.amostra;
                        canal_cap_r <= sel_r;
                        valido_r    <= 1'b1;
                        cnt_r       <= '0;
                        sel_r       <= proximo_s;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    ocupado_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel       = sel_r;
    assign bus.captura   = captura_r;
    assign bus.canal_cap = canal_cap_r;
    assign bus.valido    = valido_r;
    assign bus.ocupado   = ocupado_r;
endmodule
